// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: receiving end of an HD44780-style LCD bus.
// Synchronizes the bus, latches a byte on each EN falling edge, decodes it as a
// command or a character, and keeps a 2x16 DDRAM mirror, address counter and busy model.
// Optional feature: define LCD_READ_EN to add the rd_bus/rd_oe read-back path.
module lcd_bus_receiver #(
    parameter int unsigned BUSY_CYCLES  = 2000,
    parameter int unsigned CLEAR_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] lcd_data,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] addr_counter,
    output logic       busy,
    output logic       display_on,
    output logic       cmd_valid,
    output logic       char_valid,
    output logic [7:0] last_byte,
    output logic       protocol_err
`ifdef LCD_READ_EN
    ,
    output logic [7:0] rd_bus,
    output logic       rd_oe
`endif
);

    localparam int unsigned CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY, S_CLEAR} state_t;

    state_t         state;
    logic           en_m, en_s, en_d;
    logic           rs_m, rs_s, rw_m, rw_s;
    logic [7:0]     data_m, data_s;
    logic           fall;
    logic [CW-1:0]  busy_cnt;
    logic [4:0]     fill_idx;
    logic           fill_run;
    logic           id;
    logic           cgram_mode;
    logic           visible;
    logic [7:0]     mirror [32];
    logic           wr_en;
    logic [4:0]     wr_idx;
    logic [7:0]     wr_data;

    // AC step on the 2-line map: the gaps 0x28-0x3F and 0x68-0x7F are skipped
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h27)      return 7'h40;
            else if (a == 7'h67) return 7'h00;
            else                 return a + 7'd1;
        end else begin
            if (a == 7'h00)      return 7'h67;
            else if (a == 7'h40) return 7'h27;
            else                 return a - 7'd1;
        end
    endfunction

    assign fall    = en_d & ~en_s;
    assign visible = (addr_counter[5:4] == 2'b00);

    // Two-flop synchronizers plus one extra EN stage for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            en_m <= 1'b0; en_s <= 1'b0; en_d <= 1'b0;
            rs_m <= 1'b0; rs_s <= 1'b0;
            rw_m <= 1'b0; rw_s <= 1'b0;
            data_m <= '0; data_s <= '0;
        end else begin
            en_m <= lcd_en;   en_s <= en_m;   en_d <= en_s;
            rs_m <= lcd_rs;   rs_s <= rs_m;
            rw_m <= lcd_rw;   rw_s <= rw_m;
            data_m <= lcd_data; data_s <= data_m;
        end
    end

    // Mirror write port: space fill during INIT/CLEAR, else an accepted visible character
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = fill_idx;
        wr_data = 8'h20;
        if (!reset) begin
            if (state == S_INIT || (state == S_CLEAR && fill_run)) begin
                wr_en = 1'b1;
            end else if (state == S_IDLE && fall && !rw_s && rs_s && !cgram_mode && visible) begin
                wr_en   = 1'b1;
                wr_idx  = {addr_counter[6], addr_counter[3:0]};
                wr_data = data_s;
            end
        end
    end

    // Mirror storage; not reset, INIT refills it
    always_ff @(posedge clk) begin
        if (wr_en) mirror[wr_idx] <= wr_data;
    end

    // Registered read port; same-cycle write to the same entry returns old data
    always_ff @(posedge clk) begin
        if (reset) rd_char <= 8'h20;
        else       rd_char <= mirror[rd_addr];
    end

    // Main controller: strobe decode, address counter and busy timing
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_INIT;
            fill_idx     <= '0;
            fill_run     <= 1'b0;
            busy_cnt     <= '0;
            addr_counter <= '0;
            id           <= 1'b1;
            cgram_mode   <= 1'b0;
            display_on   <= 1'b0;
            busy         <= 1'b1;
            cmd_valid    <= 1'b0;
            char_valid   <= 1'b0;
            last_byte    <= '0;
            protocol_err <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            char_valid <= 1'b0;
            if (fall && rw_s) begin
`ifdef LCD_READ_EN
                if (rs_s) addr_counter <= ac_step(addr_counter, id);
`endif
            end else if (fall && busy) begin
                protocol_err <= 1'b1;
            end
            case (state)
                S_INIT: begin
                    fill_idx <= fill_idx + 5'd1;
                    if (fill_idx == 5'd31) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (fall && !rw_s) begin
                        last_byte <= data_s;
                        busy      <= 1'b1;
                        state     <= S_BUSY;
                        busy_cnt  <= CW'(BUSY_CYCLES - 1);
                        if (rs_s) begin
                            char_valid <= 1'b1;
                            if (!cgram_mode) addr_counter <= ac_step(addr_counter, id);
                        end else begin
                            cmd_valid <= 1'b1;
                            casez (data_s)
                                8'b1???????: begin
                                    addr_counter <= data_s[6:0];
                                    cgram_mode   <= 1'b0;
                                end
                                8'b01??????: cgram_mode <= 1'b1;
                                8'b001?????: ;
                                8'b0001????: if (!data_s[3]) addr_counter <= ac_step(addr_counter, data_s[2]);
                                8'b00001???: display_on <= data_s[2];
                                8'b000001??: id <= data_s[1];
                                8'b0000001?: addr_counter <= '0;
                                8'b00000001: begin
                                    state        <= S_CLEAR;
                                    busy_cnt     <= CW'(CLEAR_CYCLES - 1);
                                    fill_idx     <= '0;
                                    fill_run     <= 1'b1;
                                    addr_counter <= '0;
                                    id           <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_BUSY: begin
                    if (busy_cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        busy_cnt <= busy_cnt - CW'(1);
                    end
                end
                S_CLEAR: begin
                    if (fill_run) begin
                        fill_idx <= fill_idx + 5'd1;
                        if (fill_idx == 5'd31) fill_run <= 1'b0;
                    end
                    if (busy_cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        busy_cnt <= busy_cnt - CW'(1);
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

`ifdef LCD_READ_EN
    // Read-back bus: status/AC for RS=0, mirror at AC for RS=1
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_bus <= '0;
            rd_oe  <= 1'b0;
        end else begin
            rd_oe  <= en_s & rw_s;
            rd_bus <= rs_s ? mirror[{addr_counter[6], addr_counter[3:0]}] : {busy, addr_counter};
        end
    end
`endif

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Self-checking bench for lcd_bus_receiver (default build, LCD_READ_EN undefined).
// Busy timings are shortened through parameter overrides to keep the run short.
module tb_lcd_bus_receiver;

    localparam int unsigned TB_BUSY  = 40;
    localparam int unsigned TB_CLEAR = 3000;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic [6:0] addr_counter;
    logic       busy, display_on, cmd_valid, char_valid, protocol_err;
    logic [7:0] last_byte;

    lcd_bus_receiver #(.BUSY_CYCLES(TB_BUSY), .CLEAR_CYCLES(TB_CLEAR)) dut (
        .clk(clk), .reset(reset), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_en(lcd_en), .rd_addr(rd_addr), .rd_char(rd_char), .addr_counter(addr_counter),
        .busy(busy), .display_on(display_on), .cmd_valid(cmd_valid), .char_valid(char_valid),
        .last_byte(last_byte), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int char_cnt = 0;
    int cmd_cnt = 0;

    // reference model state
    logic [7:0] mm [32];
    int         ac_m;
    bit         id_m, disp_m, cg_m, perr_m;
    logic [7:0] lb_m;

    always @(negedge clk) begin
        if (char_valid === 1'b1) char_cnt++;
        if (cmd_valid === 1'b1) cmd_cnt++;
    end

    function automatic int step_m(int a, bit inc);
        if (inc) begin
            if (a == 39) return 64;
            if (a == 103) return 0;
            return (a + 1) % 128;
        end
        if (a == 0) return 103;
        if (a == 64) return 39;
        return a - 1;
    endfunction

    function automatic int vis_idx(int a);
        if ((a % 64) >= 16) return -1;
        return (a / 64) * 16 + (a % 16);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mm[i] = 8'h20;
        ac_m = 0; id_m = 1; disp_m = 0; cg_m = 0; perr_m = 0; lb_m = 8'h00;
    endtask

    task automatic readback_mirror();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk); rd_addr = 5'(i);
            @(negedge clk);
            vectors++;
            if (rd_char !== mm[i]) begin
                miscompares++;
                $display("FAIL mirror[%0d]: got %h expected %h", i, rd_char, mm[i]);
            end
        end
    endtask

    task automatic do_write(input bit rs, input logic [7:0] d);
        int c0, m0, bc, idx, exp_busy;
        bit seen, wcheck;
        logic [7:0] old_v;
        idx = rs ? vis_idx(ac_m) : -1;
        wcheck = rs && !cg_m && (idx >= 0);
        old_v = 8'h00;
        if (wcheck) begin rd_addr = 5'(idx); old_v = mm[idx]; end
        c0 = char_cnt; m0 = cmd_cnt;
        exp_busy = TB_BUSY; lb_m = d;
        if (rs) begin
            if (!cg_m) begin
                if (idx >= 0) mm[idx] = d;
                ac_m = step_m(ac_m, id_m);
            end
        end else if (d >= 128) begin ac_m = int'(d) - 128; cg_m = 0; end
        else if (d >= 64) cg_m = 1;
        else if (d >= 32) begin end
        else if (d >= 16) begin if (d[3] == 1'b0) ac_m = step_m(ac_m, d[2]); end
        else if (d >= 8) disp_m = d[2];
        else if (d >= 4) id_m = d[1];
        else if (d >= 2) ac_m = 0;
        else if (d == 1) begin
            for (int i = 0; i < 32; i++) mm[i] = 8'h20;
            ac_m = 0; id_m = 1; exp_busy = TB_CLEAR;
        end
        @(negedge clk); lcd_rs = rs; lcd_rw = 1'b0; lcd_data = d; lcd_en = 1'b1;
        repeat (3) @(negedge clk);
        lcd_en = 1'b0;
        bc = 0; seen = 0;
        for (int i = 0; i < int'(TB_CLEAR) + 200; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                if (wcheck && bc == 0) begin
                    vectors++;
                    if (rd_char !== old_v) begin
                        miscompares++;
                        $display("FAIL rd_same_cycle_old: got %h expected %h", rd_char, old_v);
                    end
                end
                if (wcheck && bc == 1) begin
                    vectors++;
                    if (rd_char !== d) begin
                        miscompares++;
                        $display("FAIL rd_after_write: got %h expected %h", rd_char, d);
                    end
                end
                bc++; seen = 1;
            end else if (seen) break;
        end
        vectors++;
        if (bc != exp_busy) begin miscompares++; $display("FAIL busy_len(%h): got %0d expected %0d", d, bc, exp_busy); end
        vectors++;
        if (addr_counter !== 7'(ac_m)) begin miscompares++; $display("FAIL ac(%h): got %h expected %h", d, addr_counter, 7'(ac_m)); end
        vectors++;
        if (display_on !== disp_m) begin miscompares++; $display("FAIL display_on: got %b expected %b", display_on, disp_m); end
        vectors++;
        if (last_byte !== lb_m) begin miscompares++; $display("FAIL last_byte: got %h expected %h", last_byte, lb_m); end
        vectors++;
        if (protocol_err !== perr_m) begin miscompares++; $display("FAIL protocol_err: got %b expected %b", protocol_err, perr_m); end
        vectors++;
        if (char_cnt - c0 != (rs ? 1 : 0)) begin miscompares++; $display("FAIL char_pulses: got %0d expected %0d", char_cnt - c0, rs ? 1 : 0); end
        vectors++;
        if (cmd_cnt - m0 != (rs ? 0 : 1)) begin miscompares++; $display("FAIL cmd_pulses: got %0d expected %0d", cmd_cnt - m0, rs ? 0 : 1); end
    endtask

    task automatic test_reset();
        int cnt;
        reset = 1'b1; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00; rd_addr = 5'd0;
        repeat (4) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || addr_counter !== 7'h00 || display_on !== 1'b0 || cmd_valid !== 1'b0 ||
            char_valid !== 1'b0 || last_byte !== 8'h00 || protocol_err !== 1'b0 || rd_char !== 8'h20) begin
            miscompares++;
            $display("FAIL reset_values: busy=%b ac=%h disp=%b cmdv=%b charv=%b lb=%h perr=%b rd=%h",
                     busy, addr_counter, display_on, cmd_valid, char_valid, last_byte, protocol_err, rd_char);
        end
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy !== 1'b1) break;
            cnt++;
            @(negedge clk);
        end
        vectors++;
        if (cnt != 32) begin miscompares++; $display("FAIL init_busy_len: got %0d expected 32", cnt); end
        model_reset();
        readback_mirror();
    endtask

    task automatic test_spec_sequence();
        do_write(0, 8'h80); do_write(1, 8'h41); do_write(1, 8'h42);
        vectors++;
        if (addr_counter !== 7'h02) begin miscompares++; $display("FAIL ac_after_AB: got %h expected 02", addr_counter); end
        do_write(0, 8'hC0); do_write(1, 8'h5A);
        vectors++;
        if (addr_counter !== 7'h41) begin miscompares++; $display("FAIL ac_after_Z: got %h expected 41", addr_counter); end
        do_write(0, 8'hA7); do_write(1, 8'h51);
        vectors++;
        if (addr_counter !== 7'h40) begin miscompares++; $display("FAIL ac_wrap_27: got %h expected 40", addr_counter); end
        do_write(0, 8'h04); do_write(0, 8'h80); do_write(1, 8'h78);
        vectors++;
        if (addr_counter !== 7'h67) begin miscompares++; $display("FAIL ac_wrap_dec: got %h expected 67", addr_counter); end
        do_write(0, 8'h06); do_write(0, 8'hE7); do_write(1, 8'h79);
        vectors++;
        if (addr_counter !== 7'h00) begin miscompares++; $display("FAIL ac_wrap_67: got %h expected 00", addr_counter); end
        do_write(0, 8'h04); do_write(0, 8'hC0); do_write(1, 8'h2E);
        vectors++;
        if (addr_counter !== 7'h27) begin miscompares++; $display("FAIL ac_wrap_40: got %h expected 27", addr_counter); end
        do_write(0, 8'h06);
        readback_mirror();
    endtask

    task automatic test_display_cgram();
        do_write(0, 8'h0C);
        vectors++;
        if (display_on !== 1'b1) begin miscompares++; $display("FAIL display_on_set: got %b expected 1", display_on); end
        do_write(0, 8'h08);
        do_write(0, 8'h85); do_write(0, 8'h48); do_write(1, 8'h6B);
        vectors++;
        if (addr_counter !== 7'h05) begin miscompares++; $display("FAIL cgram_drop_ac: got %h expected 05", addr_counter); end
        do_write(0, 8'h1C); do_write(0, 8'h10); do_write(0, 8'h14);
        do_write(0, 8'h85); do_write(1, 8'h6D);
        vectors++;
        if (addr_counter !== 7'h06) begin miscompares++; $display("FAIL ddram_resume_ac: got %h expected 06", addr_counter); end
        do_write(0, 8'h02); do_write(0, 8'h00); do_write(0, 8'h3F);
        readback_mirror();
    endtask

    task automatic test_rw_ignored();
        int c0, m0, bc;
        c0 = char_cnt; m0 = cmd_cnt;
        @(negedge clk); lcd_rw = 1'b1; lcd_rs = 1'($urandom_range(0, 1)); lcd_data = 8'h55; lcd_en = 1'b1;
        repeat (3) @(negedge clk);
        lcd_en = 1'b0;
        bc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) bc++;
        end
        lcd_rw = 1'b0;
        vectors++;
        if (bc != 0) begin miscompares++; $display("FAIL rw_busy: got %0d busy cycles expected 0", bc); end
        vectors++;
        if (char_cnt != c0 || cmd_cnt != m0) begin miscompares++; $display("FAIL rw_pulses: got %0d expected 0", char_cnt - c0 + cmd_cnt - m0); end
        vectors++;
        if (addr_counter !== 7'(ac_m) || last_byte !== lb_m) begin
            miscompares++; $display("FAIL rw_state: ac=%h lb=%h expected ac=%h lb=%h", addr_counter, last_byte, 7'(ac_m), lb_m);
        end
    endtask

    task automatic test_random();
        int sel;
        logic [7:0] d;
        for (int n = 0; n < 150; n++) begin
            sel = int'($urandom_range(0, 3));
            if (sel <= 1) do_write(1, 8'($urandom_range(32, 126)));
            else if (sel == 2) begin
                d = 8'($urandom_range(0, 255));
                if (d == 8'h01) d = 8'h0C;
                do_write(0, d);
            end else do_write(0, 8'h80 | 8'($urandom_range(0, 1) * 64) | 8'($urandom_range(0, 15)));
            if (n % 50 == 49) readback_mirror();
        end
    endtask

    task automatic test_clear();
        int c0, m0, bc;
        bit seen;
        c0 = char_cnt; m0 = cmd_cnt;
        @(negedge clk); lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h01; lcd_en = 1'b1;
        repeat (3) @(negedge clk);
        lcd_en = 1'b0;
        bc = 0; seen = 0;
        for (int i = 0; i < int'(TB_CLEAR) + 200; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                bc++; seen = 1;
                if (bc == 100) begin lcd_rs = 1'b1; lcd_data = 8'h77; lcd_en = 1'b1; end
                if (bc == 104) lcd_en = 1'b0;
            end else if (seen) break;
        end
        for (int i = 0; i < 32; i++) mm[i] = 8'h20;
        ac_m = 0; id_m = 1; perr_m = 1; lb_m = 8'h01;
        vectors++;
        if (bc != int'(TB_CLEAR)) begin miscompares++; $display("FAIL clear_busy_len: got %0d expected %0d", bc, TB_CLEAR); end
        vectors++;
        if (protocol_err !== 1'b1) begin miscompares++; $display("FAIL clear_perr: got %b expected 1", protocol_err); end
        vectors++;
        if (char_cnt != c0 || cmd_cnt - m0 != 1) begin
            miscompares++; $display("FAIL clear_pulses: chars %0d cmds %0d expected 0 and 1", char_cnt - c0, cmd_cnt - m0);
        end
        vectors++;
        if (addr_counter !== 7'h00 || last_byte !== 8'h01) begin
            miscompares++; $display("FAIL clear_state: ac=%h lb=%h expected 00 01", addr_counter, last_byte);
        end
        readback_mirror();
        do_write(1, 8'h63); do_write(1, 8'h64);
    endtask

    task automatic test_reset_in_clear();
        int bc;
        @(negedge clk); lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h01; lcd_en = 1'b1;
        repeat (3) @(negedge clk);
        lcd_en = 1'b0;
        bc = 0;
        for (int i = 0; i < 200 && bc < 10; i++) begin
            @(negedge clk);
            if (busy === 1'b1) bc++;
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || addr_counter !== 7'h00 || display_on !== 1'b0 || cmd_valid !== 1'b0 ||
            char_valid !== 1'b0 || last_byte !== 8'h00 || protocol_err !== 1'b0 || rd_char !== 8'h20) begin
            miscompares++;
            $display("FAIL reset_in_clear: busy=%b ac=%h disp=%b cmdv=%b charv=%b lb=%h perr=%b rd=%h",
                     busy, addr_counter, display_on, cmd_valid, char_valid, last_byte, protocol_err, rd_char);
        end
        reset = 1'b0;
        bc = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy !== 1'b1) break;
            bc++;
            @(negedge clk);
        end
        vectors++;
        if (bc != 32) begin miscompares++; $display("FAIL reinit_busy_len: got %0d expected 32", bc); end
        model_reset();
        readback_mirror();
        do_write(1, 8'h4B);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_spec_sequence();
        test_display_cgram();
        test_rw_ignored();
        test_random();
        test_clear();
        test_reset_in_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
